// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - EX, dcache, WB and forwarding signals of the memory stage
interface mem_stage_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int REG_W = 6
);
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_alu_result;
    logic [XLEN-1:0]   ex_rs2;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_wb_en;
    logic              ex_mem_en;
    logic              ex_load;
    logic [1:0]        ex_size;
    logic              ex_unsigned;
    logic              ex_ecall;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_load;
    logic [XLEN-1:0]   dc_req_addr;
    logic [XLEN-1:0]   dc_req_wdata;
    logic [XLEN/8-1:0] dc_req_bmask;
    logic              dc_resp_valid;
    logic [XLEN-1:0]   dc_resp_data;

    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              wb_en;
    logic              wb_ecall;
    logic              wb_misalign;

    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              fwd_pending;

    modport master (
        input  ex_valid, ex_alu_result, ex_rs2, ex_rd, ex_wb_en, ex_mem_en,
               ex_load, ex_size, ex_unsigned, ex_ecall,
               dc_req_ready, dc_resp_valid, dc_resp_data, wb_ready,
        output ex_ready, dc_req_valid, dc_req_load, dc_req_addr, dc_req_wdata,
               dc_req_bmask, wb_valid, wb_rd, wb_data, wb_en, wb_ecall,
               wb_misalign, fwd_valid, fwd_rd, fwd_data, fwd_pending
    );

    modport slave (
        output ex_valid, ex_alu_result, ex_rs2, ex_rd, ex_wb_en, ex_mem_en,
               ex_load, ex_size, ex_unsigned, ex_ecall,
               dc_req_ready, dc_resp_valid, dc_resp_data, wb_ready,
        input  ex_ready, dc_req_valid, dc_req_load, dc_req_addr, dc_req_wdata,
               dc_req_bmask, wb_valid, wb_rd, wb_data, wb_en, wb_ecall,
               wb_misalign, fwd_valid, fwd_rd, fwd_data, fwd_pending
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - RISC-V MEM stage: EX/dcache/WB handshakes, load align, store steering, forwarding
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl #(
    parameter int XLEN  = 64,
    parameter int REG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_ctrl_if.master  bus
);
    localparam int BW    = XLEN / 8;
    localparam int OFF_W = $clog2(BW);

    typedef enum logic [1:0] {EMPTY, ISSUE, WAIT, FULL} state_t;

    state_t            state, state_nxt;
    logic [REG_W-1:0]  rd_q;
    logic              wb_en_q;
    logic              ecall_q;
    logic              load_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   data_q;
    logic              accept;
    logic              ex_trap;
    logic [1:0]        ex_size_eff;

    logic [OFF_W-1:0]  off;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   lane_top;
    logic [XLEN-1:0]   load_ext;
    logic [BW-1:0]     byte_base;

    // Address bits below the access size; nonzero means misaligned.
    function automatic logic [OFF_W-1:0] low_bits(input logic [1:0] sz);
        case (sz)
            2'd0:    low_bits = '0;
            2'd1:    low_bits = OFF_W'(1);
            2'd2:    low_bits = OFF_W'(3);
            default: low_bits = OFF_W'(7);
        endcase
    endfunction

    assign ex_size_eff = (XLEN == 32 && bus.ex_size == 2'd3) ? 2'd2 : bus.ex_size;
    assign accept      = bus.ex_valid && bus.ex_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign ex_trap = bus.ex_mem_en && |(bus.ex_alu_result[OFF_W-1:0] & low_bits(ex_size_eff));
`else
    assign ex_trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, FULL: begin
                if (state == EMPTY || bus.wb_ready) begin
                    if (bus.ex_valid)
                        state_nxt = (bus.ex_mem_en && !ex_trap) ? ISSUE : FULL;
                    else
                        state_nxt = EMPTY;
                end
            end
            ISSUE: if (bus.dc_req_ready) state_nxt = load_q ? WAIT : FULL;
            WAIT:  if (bus.dc_resp_valid) state_nxt = FULL;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        off       = addr_q[OFF_W-1:0] & ~low_bits(size_q);
        shifted   = bus.dc_resp_data >> {off, 3'b000};
        case (size_q)
            2'd0:    begin lane_mask = XLEN'(8'hFF);         byte_base = BW'(1);     end
            2'd1:    begin lane_mask = XLEN'(16'hFFFF);      byte_base = BW'(3);     end
            2'd2:    begin lane_mask = XLEN'(32'hFFFF_FFFF); byte_base = BW'(4'hF);  end
            default: begin lane_mask = '1;                   byte_base = BW'(8'hFF); end
        endcase
        lane_top = lane_mask & ~(lane_mask >> 1);
        load_ext = (!uns_q && |(shifted & lane_top)) ? (shifted | ~lane_mask)
                                                     : (shifted & lane_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            ecall_q <= 1'b0;
            load_q  <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            rs2_q   <= '0;
            data_q  <= '0;
        end else if (accept) begin
            rd_q    <= bus.ex_rd;
            wb_en_q <= bus.ex_wb_en && !ex_trap;
            ecall_q <= bus.ex_ecall;
            load_q  <= bus.ex_mem_en && bus.ex_load;
            size_q  <= ex_size_eff;
            uns_q   <= bus.ex_unsigned;
            addr_q  <= bus.ex_alu_result;
            rs2_q   <= bus.ex_rs2;
            // ALU result, store address and trap address all land here directly.
            data_q  <= bus.ex_alu_result;
        end else if (state == WAIT && bus.dc_resp_valid) begin
            data_q  <= load_ext;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       misalign_q <= 1'b0;
        else if (accept) misalign_q <= ex_trap;
    end
    assign bus.wb_misalign = misalign_q;
`else
    assign bus.wb_misalign = 1'b0;
`endif

    always_comb begin
        bus.ex_ready     = (state == EMPTY) || (state == FULL && bus.wb_ready);
        bus.dc_req_valid = (state == ISSUE);
        bus.dc_req_load  = (state == ISSUE) && load_q;
        bus.dc_req_addr  = '0;
        bus.dc_req_wdata = '0;
        bus.dc_req_bmask = '0;
        if (state == ISSUE) begin
            bus.dc_req_addr = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            if (!load_q) begin
                bus.dc_req_wdata = rs2_q << {off, 3'b000};
                bus.dc_req_bmask = byte_base << off;
            end
        end
        bus.wb_valid    = (state == FULL);
        bus.wb_rd       = rd_q;
        bus.wb_data     = data_q;
        bus.wb_en       = wb_en_q;
        bus.wb_ecall    = ecall_q;
        bus.fwd_valid   = (state == FULL) && wb_en_q && (rd_q != '0);
        bus.fwd_rd      = rd_q;
        bus.fwd_data    = data_q;
        bus.fwd_pending = (state == ISSUE || state == WAIT) && load_q && wb_en_q
                          && (rd_q != '0);
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.XLEN(64), .REG_W(6)) bus();

    mem_stage_ctrl #(.XLEN(64), .REG_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [5:0] rd, input logic [63:0] res, input logic [63:0] rs2,
                            input logic wb_en, input logic mem_en, input logic load,
                            input logic [1:0] size, input logic uns, input logic ecall);
        bus.ex_valid      = 1'b1;
        bus.ex_rd         = rd;
        bus.ex_alu_result = res;
        bus.ex_rs2        = rs2;
        bus.ex_wb_en      = wb_en;
        bus.ex_mem_en     = mem_en;
        bus.ex_load       = load;
        bus.ex_size       = size;
        bus.ex_unsigned   = uns;
        bus.ex_ecall      = ecall;
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_alu_result = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
        bus.ex_wb_en = 0; bus.ex_mem_en = 0; bus.ex_load = 0; bus.ex_size = '0;
        bus.ex_unsigned = 0; bus.ex_ecall = 0; bus.dc_req_ready = 0;
        bus.dc_resp_valid = 0; bus.dc_resp_data = '0; bus.wb_ready = 1;

        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_ex_ready", bus.ex_ready, 1);
        check("rst_dc_valid", bus.dc_req_valid, 0);
        check("rst_bmask",    bus.dc_req_bmask, 0);
        check("rst_wb_data",  bus.wb_data, 0);
        check("rst_fwd",      {bus.fwd_valid, bus.fwd_pending, bus.fwd_rd}, 0);

        // ALU op
        drive_ex(6'd5, 64'h1234, 0, 1, 0, 0, 2'd3, 0, 0);
        tick();
        bus.ex_valid = 0;
        #1;
        check("alu_wb_valid", bus.wb_valid, 1);
        check("alu_wb_data",  bus.wb_data, 64'h1234);
        check("alu_fwd",      {bus.fwd_valid, bus.fwd_rd}, {1'b1, 6'd5});
        check("alu_fwd_data", bus.fwd_data, 64'h1234);
        tick();
        check("alu_drain", bus.wb_valid, 0);

        // back-to-back accept, second carries ecall
        drive_ex(6'd7, 64'hAAAA, 0, 1, 0, 0, 2'd3, 0, 0);
        tick();
        drive_ex(6'd8, 64'hBBBB, 0, 1, 0, 0, 2'd3, 0, 1);
        #1;
        check("b2b_ready", bus.ex_ready, 1);
        check("b2b_first", bus.wb_data, 64'hAAAA);
        tick();
        bus.ex_valid = 0;
        check("b2b_second", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 6'd8, 64'hBBBB});
        check("ecall_pass", bus.wb_ecall, 1);
        tick();

        // LB with dcache stall and WB backpressure
        drive_ex(6'd10, 64'h1003, 0, 1, 1, 1, 2'd0, 0, 0);
        tick();
        bus.ex_valid = 0;
        #1;
        check("lb_issue", {bus.dc_req_valid, bus.dc_req_load}, 2'b11);
        check("lb_addr", bus.dc_req_addr, 64'h1000);
        check("lb_pending", bus.fwd_pending, 1);
        for (int i = 0; i < 3; i++) tick();
        check("lb_hold", {bus.dc_req_valid, bus.ex_ready, bus.fwd_pending, bus.dc_req_addr},
              {1'b1, 1'b0, 1'b1, 64'h1000});
        bus.dc_req_ready = 1;
        tick();
        bus.dc_req_ready = 0;
        bus.dc_resp_data = 64'h0000_0000_8A00_0000;
        #1;
        check("lb_wait", {bus.dc_req_valid, bus.fwd_pending, bus.wb_valid}, 3'b010);
        bus.dc_resp_valid = 1;
        bus.wb_ready = 0;
        tick();
        bus.dc_resp_valid = 0;
        check("lb_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FF8A);
        tick(); tick();
        check("lb_held", {bus.wb_valid, bus.ex_ready, bus.fwd_valid}, 3'b101);
        check("lb_held_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FF8A);
        bus.wb_ready = 1;
        tick();

        // LBU, same stimulus, dcache ready immediately
        bus.dc_req_ready = 1;
        drive_ex(6'd10, 64'h1003, 0, 1, 1, 1, 2'd0, 1, 0);
        tick();
        bus.ex_valid = 0;
        tick();
        bus.dc_req_ready = 0;
        bus.dc_resp_valid = 1;
        tick();
        bus.dc_resp_valid = 0;
        check("lbu_data", bus.wb_data, 64'h8A);
        tick();

        // SH lane steering
        drive_ex(6'd0, 64'h1006, 64'hBEEF, 0, 1, 0, 2'd1, 0, 0);
        tick();
        bus.ex_valid = 0;
        #1;
        check("sh_wdata", bus.dc_req_wdata, 64'hBEEF_0000_0000_0000);
        check("sh_bmask", bus.dc_req_bmask, 64'hC0);
        check("sh_addr",  bus.dc_req_addr, 64'h1000);
        check("sh_nofwd", {bus.fwd_pending, bus.fwd_valid, bus.dc_req_load}, 0);
        bus.dc_req_ready = 1;
        tick();
        bus.dc_req_ready = 0;
        check("sh_done", {bus.wb_valid, bus.wb_data}, {1'b1, 64'h1006});
        tick();

        // reset while waiting for load data
        bus.dc_req_ready = 1;
        drive_ex(6'd3, 64'h2000, 0, 1, 1, 1, 2'd3, 0, 0);
        tick();
        bus.ex_valid = 0;
        tick();
        bus.dc_req_ready = 0;
        reset = 1;
        #2;
        reset = 0;
        bus.dc_resp_valid = 1;
        bus.dc_resp_data = 64'h5555;
        tick();
        bus.dc_resp_valid = 0;
        check("rstwait_state", {bus.wb_valid, bus.ex_ready, bus.dc_req_valid}, 3'b010);
        tick();
        check("rstwait_data", {bus.wb_valid, bus.wb_data}, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        // misaligned LW traps without a dcache request
        bus.dc_req_ready = 1;
        drive_ex(6'd4, 64'h1002, 0, 1, 1, 1, 2'd2, 0, 0);
        #1;
        check("mis_no_req0", bus.dc_req_valid, 0);
        tick();
        bus.ex_valid = 0;
        bus.dc_req_ready = 0;
        check("mis_no_req1", bus.dc_req_valid, 0);
        check("mis_bundle", {bus.wb_valid, bus.wb_misalign, bus.wb_en}, 3'b110);
        check("mis_data", bus.wb_data, 64'h1002);
        tick();
`else
        // misaligned LW is naturally aligned to the containing word
        bus.dc_req_ready = 1;
        drive_ex(6'd4, 64'h1002, 0, 1, 1, 1, 2'd2, 0, 0);
        tick();
        bus.ex_valid = 0;
        tick();
        bus.dc_req_ready = 0;
        bus.dc_resp_data = 64'h1122_3344_8899_AABB;
        bus.dc_resp_valid = 1;
        tick();
        bus.dc_resp_valid = 0;
        check("lw_align", bus.wb_data, 64'hFFFF_FFFF_8899_AABB);
        check("lw_nomis", {bus.wb_misalign, bus.wb_en}, 2'b01);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
